// File: rtl/core_ifu_imem_resp.sv
// rtl/core_ifu_imem_resp.sv - timed instruction-memory responder for the IFU fetch interface
module core_ifu_imem_resp #(
    parameter int              PC_W       = 32,
    parameter int              INST_W     = 32,
    parameter int              DEPTH_LOG2 = 10,
    parameter logic [PC_W-1:0] BASE_ADDR  = 'h8000_0000,
    parameter int              LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [PC_W-1:0]       req_pc,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [INST_W-1:0]     resp_inst,
    output logic                  resp_err,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] wr_addr,
    input  logic [INST_W-1:0]     wr_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam state_t          POST_ACCEPT = (LATENCY == 1) ? RESP : WAIT;
    localparam logic [3:0]      CNT_INIT    = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;
    localparam logic [INST_W-1:0] NOP_INST  = INST_W'(32'h0000_0013);

    logic [INST_W-1:0] mem [0:(2**DEPTH_LOG2)-1];

    state_t            state;
    state_t            state_next;
    logic [3:0]        cnt;
    logic              accept;
    logic [PC_W-1:0]   off;
    logic              misaligned;
    logic              out_of_range;
    logic              fetch_err;
    logic [INST_W-1:0] fetch_inst;
    logic              unused_off_lsbs;

    // Offset bits above the word index must be zero for an in-range fetch.
    assign off             = req_pc - BASE_ADDR;
    assign misaligned      = (req_pc[1:0] != 2'b00);
    assign out_of_range    = (req_pc < BASE_ADDR) || (off[PC_W-1:DEPTH_LOG2+2] != '0);
    assign fetch_err       = misaligned || out_of_range;
    assign fetch_inst      = fetch_err ? NOP_INST : mem[off[DEPTH_LOG2+1:2]];
    assign unused_off_lsbs = ^off[1:0];

    assign req_ready = rst_n && !flush &&
                       ((state == IDLE) || ((state == RESP) && resp_ready));
    assign accept    = req_valid && req_ready;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = POST_ACCEPT;
            WAIT:    if (cnt == 4'd0) state_next = RESP;
            RESP:    if (resp_ready) state_next = accept ? POST_ACCEPT : IDLE;
            default: state_next = IDLE;
        endcase
        if (flush) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            resp_valid <= 1'b0;
            resp_inst  <= '0;
            resp_err   <= 1'b0;
        end else begin
            state      <= state_next;
            resp_valid <= (state_next == RESP);
            if (accept) begin
                resp_inst <= fetch_inst;
                resp_err  <= fetch_err;
                cnt       <= CNT_INIT;
            end else if ((state == WAIT) && (cnt != 4'd0)) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    // Read happens combinationally in the accept cycle, so a same-edge write is not seen.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

endmodule

// File: tb/tb_core_ifu_imem_resp.sv
// tb/tb_core_ifu_imem_resp.sv - self-checking bench for core_ifu_imem_resp
module tb_core_ifu_imem_resp;

    localparam int          LAT  = 2;
    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam logic [31:0] NOP  = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_pc = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_inst;
    logic        resp_err;
    logic        flush = 1'b0;
    logic        wr_en = 1'b0;
    logic [9:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;

    int          tests_run = 0;
    int          tests_failed = 0;
    int          cyc = 0;
    logic [31:0] ref_mem [0:1023];

    always #5 clk = ~clk;

    core_ifu_imem_resp #(
        .PC_W(32), .INST_W(32), .DEPTH_LOG2(10), .BASE_ADDR(BASE), .LATENCY(LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_pc(req_pc), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_inst(resp_inst), .resp_err(resp_err), .flush(flush),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic void ref_fetch(input logic [31:0] pc, output logic [31:0] inst,
                                      output logic err);
        longint off;
        off  = longint'(pc) - longint'(BASE);
        err  = (pc[1:0] != 2'b00) || (off < 0) || (off >= 4 * 1024);
        inst = err ? NOP : ref_mem[int'(off >>> 2)];
    endfunction

    task automatic preload();
        for (int i = 0; i < 65; i++) begin
            step();
            wr_en   = 1'b1;
            wr_addr = (i == 64) ? 10'd1023 : 10'(i);
            wr_data = (i == 0) ? 32'h0010_0093 : $urandom;
            ref_mem[wr_addr] = wr_data;
        end
        step();
        wr_en = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(); step();
        tests_run++; if (req_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_req_ready got %0b want 0", req_ready); end
        tests_run++; if (resp_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_resp_valid got %0b want 0", resp_valid); end
        tests_run++; if (resp_inst !== 32'h0) begin tests_failed++; $display("FAIL reset_resp_inst got %h want 0", resp_inst); end
        tests_run++; if (resp_err !== 1'b0) begin tests_failed++; $display("FAIL reset_resp_err got %0b want 0", resp_err); end
        rst_n = 1'b1;
        #1;
        tests_run++; if (req_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_release_ready got %0b want 1", req_ready); end
    endtask

    task automatic test_basic();
        step(); req_valid = 1'b1; req_pc = BASE; resp_ready = 1'b0; #1;
        tests_run++; if (req_ready !== 1'b1) begin tests_failed++; $display("FAIL basic_accept got %0b want 1", req_ready); end
        step(); req_valid = 1'b0; #1;
        tests_run++; if (resp_valid !== 1'b0) begin tests_failed++; $display("FAIL basic_early_valid got %0b want 0", resp_valid); end
        step(); resp_ready = 1'b1; #1;
        tests_run++; if (resp_valid !== 1'b1) begin tests_failed++; $display("FAIL basic_valid got %0b want 1", resp_valid); end
        tests_run++; if (resp_inst !== 32'h0010_0093) begin tests_failed++; $display("FAIL basic_inst got %h want 00100093", resp_inst); end
        tests_run++; if (resp_err !== 1'b0) begin tests_failed++; $display("FAIL basic_err got %0b want 0", resp_err); end
        step(); resp_ready = 1'b0; #1;
        tests_run++; if (resp_valid !== 1'b0) begin tests_failed++; $display("FAIL basic_after_valid got %0b want 0", resp_valid); end
    endtask

    task automatic test_stall();
        step(); req_valid = 1'b1; req_pc = BASE + 32'd4; resp_ready = 1'b0; #1;
        step(); req_valid = 1'b0;
        step();
        req_valid = 1'b1; req_pc = BASE + 32'd8;
        for (int i = 0; i < 5; i++) begin
            #1;
            tests_run++; if (resp_valid !== 1'b1 || resp_inst !== ref_mem[1]) begin tests_failed++; $display("FAIL stall_hold cycle %0d got valid=%0b inst=%h want 1/%h", i, resp_valid, resp_inst, ref_mem[1]); end
            tests_run++; if (req_ready !== 1'b0) begin tests_failed++; $display("FAIL stall_ready cycle %0d got %0b want 0", i, req_ready); end
            step();
        end
        req_valid = 1'b0; resp_ready = 1'b1; #1;
        tests_run++; if (resp_valid !== 1'b1 || req_ready !== 1'b1) begin tests_failed++; $display("FAIL stall_release got valid=%0b ready=%0b want 1/1", resp_valid, req_ready); end
        step(); resp_ready = 1'b0; #1;
        tests_run++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin tests_failed++; $display("FAIL stall_idle got valid=%0b ready=%0b want 0/1", resp_valid, req_ready); end
    endtask

    task automatic test_stream();
        for (int k = 0; k < 7; k++) begin
            step();
            resp_ready = 1'b1;
            req_valid  = (k < 5);
            req_pc     = BASE + 32'(4 * ((k + 1) / 2));
            #1;
            tests_run++; if (req_ready !== ((k % 2) == 0)) begin tests_failed++; $display("FAIL stream_ready k=%0d got %0b want %0b", k, req_ready, (k % 2) == 0); end
            tests_run++; if (resp_valid !== (k >= 2 && (k % 2) == 0)) begin tests_failed++; $display("FAIL stream_valid k=%0d got %0b", k, resp_valid); end
            if (k >= 2 && (k % 2) == 0) begin
                tests_run++; if (resp_inst !== ref_mem[k / 2 - 1]) begin tests_failed++; $display("FAIL stream_inst k=%0d got %h want %h", k, resp_inst, ref_mem[k / 2 - 1]); end
            end
        end
        step(); req_valid = 1'b0; resp_ready = 1'b0; #1;
        tests_run++; if (resp_valid !== 1'b0) begin tests_failed++; $display("FAIL stream_end got %0b want 0", resp_valid); end
    endtask

    task automatic test_fault();
        logic [31:0] pcs [5];
        logic [31:0] e_inst;
        logic        e_err;
        pcs = '{32'h8000_0002, 32'h8000_1000, 32'h7FFF_FFFC, 32'h8000_0FFF, 32'h8000_0FFC};
        foreach (pcs[i]) begin
            ref_fetch(pcs[i], e_inst, e_err);
            step(); req_valid = 1'b1; req_pc = pcs[i]; resp_ready = 1'b1; #1;
            step(); req_valid = 1'b0;
            step(); #1;
            tests_run++; if (resp_valid !== 1'b1 || resp_err !== e_err || resp_inst !== e_inst) begin tests_failed++; $display("FAIL fault pc=%h got v=%0b err=%0b inst=%h want 1/%0b/%h", pcs[i], resp_valid, resp_err, resp_inst, e_err, e_inst); end
        end
    endtask

    task automatic test_flush();
        step(); req_valid = 1'b1; req_pc = BASE; resp_ready = 1'b1; #1;
        step(); req_pc = BASE + 32'd8; flush = 1'b1; #1;
        tests_run++; if (req_ready !== 1'b0) begin tests_failed++; $display("FAIL flush_ready got %0b want 0", req_ready); end
        step(); flush = 1'b0; req_valid = 1'b0; #1;
        tests_run++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin tests_failed++; $display("FAIL flush_drop got valid=%0b ready=%0b want 0/1", resp_valid, req_ready); end
        step(); #1;
        tests_run++; if (resp_valid !== 1'b0) begin tests_failed++; $display("FAIL flush_late got %0b want 0", resp_valid); end
        step(); req_valid = 1'b1; req_pc = BASE + 32'd4; #1;
        tests_run++; if (req_ready !== 1'b1) begin tests_failed++; $display("FAIL flush_next_accept got %0b want 1", req_ready); end
        step(); req_valid = 1'b0;
        step(); #1;
        tests_run++; if (resp_valid !== 1'b1 || resp_inst !== ref_mem[1]) begin tests_failed++; $display("FAIL flush_next_resp got v=%0b inst=%h want 1/%h", resp_valid, resp_inst, ref_mem[1]); end
    endtask

    task automatic test_wr_collision();
        logic [31:0] old_word;
        old_word = ref_mem[3];
        step(); req_valid = 1'b1; req_pc = BASE + 32'd12; resp_ready = 1'b1;
        wr_en = 1'b1; wr_addr = 10'd3; wr_data = 32'hDEAD_BEEF; #1;
        ref_mem[3] = 32'hDEAD_BEEF;
        step(); req_valid = 1'b0; wr_en = 1'b0;
        step(); #1;
        tests_run++; if (resp_valid !== 1'b1 || resp_inst !== old_word) begin tests_failed++; $display("FAIL collide_old got v=%0b inst=%h want 1/%h", resp_valid, resp_inst, old_word); end
        step(); req_valid = 1'b1;
        step(); req_valid = 1'b0;
        step(); #1;
        tests_run++; if (resp_valid !== 1'b1 || resp_inst !== 32'hDEAD_BEEF) begin tests_failed++; $display("FAIL collide_new got v=%0b inst=%h want 1/deadbeef", resp_valid, resp_inst); end
    endtask

    task automatic test_reset_mid();
        step(); req_valid = 1'b1; req_pc = BASE; resp_ready = 1'b1; #1;
        step(); req_valid = 1'b0; rst_n = 1'b0; #1;
        tests_run++; if (req_ready !== 1'b0) begin tests_failed++; $display("FAIL rstmid_ready got %0b want 0", req_ready); end
        step(); rst_n = 1'b1; #1;
        tests_run++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin tests_failed++; $display("FAIL rstmid_idle got valid=%0b ready=%0b want 0/1", resp_valid, req_ready); end
        step(); #1;
        tests_run++; if (resp_valid !== 1'b0) begin tests_failed++; $display("FAIL rstmid_late got %0b want 0", resp_valid); end
    endtask

    // Reference: a fetch accepted at cycle T is shown from T+LAT until taken or flushed.
    task automatic test_random();
        bit          m_pending = 1'b0;
        int          m_due = 0;
        logic [31:0] m_inst = '0;
        logic        m_err = 1'b0;
        bit          exp_ready;
        bit          exp_valid;
        int          r;
        step(); req_valid = 1'b0; resp_ready = 1'b0; wr_en = 1'b0; flush = 1'b1;
        for (int n = 0; n < 800; n++) begin
            step();
            r          = int'($urandom_range(0, 9));
            req_valid  = ($urandom_range(0, 2) != 0);
            if (r < 8)       req_pc = BASE + 32'(4 * $urandom_range(0, 63));
            else if (r == 8) req_pc = BASE + 32'(4 * $urandom_range(0, 63) + $urandom_range(1, 3));
            else             req_pc = ($urandom_range(0, 1) != 0) ? BASE + 32'h1000 + 32'(4 * $urandom_range(0, 255)) : BASE - 32'(4 * $urandom_range(1, 8));
            resp_ready = ($urandom_range(0, 2) != 0);
            flush      = ($urandom_range(0, 15) == 0);
            wr_en      = ($urandom_range(0, 3) == 0);
            wr_addr    = 10'($urandom_range(0, 63));
            wr_data    = $urandom;
            #1;
            exp_ready = !flush && (!m_pending || (cyc >= m_due && resp_ready));
            exp_valid = m_pending && (cyc >= m_due);
            tests_run++; if (req_ready !== exp_ready) begin tests_failed++; $display("FAIL rand_ready n=%0d got %0b want %0b", n, req_ready, exp_ready); end
            tests_run++; if (resp_valid !== exp_valid) begin tests_failed++; $display("FAIL rand_valid n=%0d got %0b want %0b", n, resp_valid, exp_valid); end
            if (exp_valid) begin
                tests_run++; if (resp_inst !== m_inst || resp_err !== m_err) begin tests_failed++; $display("FAIL rand_data n=%0d got %h/%0b want %h/%0b", n, resp_inst, resp_err, m_inst, m_err); end
            end
            if (exp_valid && resp_ready) m_pending = 1'b0;
            if (flush) m_pending = 1'b0;
            if (req_valid && exp_ready) begin
                m_pending = 1'b1;
                m_due     = cyc + LAT;
                ref_fetch(req_pc, m_inst, m_err);
            end
            if (wr_en) ref_mem[wr_addr] = wr_data;
        end
        step(); req_valid = 1'b0; resp_ready = 1'b0; wr_en = 1'b0; flush = 1'b0;
    endtask

    initial begin
        test_reset();
        preload();
        test_basic();
        test_stall();
        test_stream();
        test_fault();
        test_flush();
        test_wr_collision();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
